// File: rtl/sram_arbiter_pkg.sv
// Shared types and sizes for the two-port SRAM arbiter.
// SRAM_ARB_INIT_EN adds the INIT state used by the power-up sweep.
package sram_arbiter_pkg;

  localparam int SRAM_DEPTH = 1024;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 8;

`ifdef SRAM_ARB_INIT_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2,
    INIT   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/sram_1k8.sv
// 1024x8 single-port SRAM with registered read data.
// dout only updates on read cycles and holds across writes.
module sram_1k8
  import sram_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [SRAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    else    dout      <= mem[addr];
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester burst arbiter in front of a 1024x8 SRAM.
// Define SRAM_ARB_INIT_EN to sweep INIT_VAL into the array after reset.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int                BURST_MAX = 4,
  parameter logic [DATA_W-1:0] INIT_VAL  = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam logic [2:0] CNT_TOP = 3'(BURST_MAX - 1);
`ifdef SRAM_ARB_INIT_EN
  localparam state_t ST_RST = INIT;
`else
  localparam state_t ST_RST = IDLE;
`endif

  state_t            state, state_nx;
  logic [2:0]        cnt, cnt_nx;
  logic              last, last_nx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

`ifdef SRAM_ARB_INIT_EN
  logic [ADDR_W-1:0] sweep;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               sweep <= '0;
    else if (state == INIT) sweep <= sweep + 1'b1;
  end

  assign busy = (state == INIT);
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RST;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    unique case (state)
`ifdef SRAM_ARB_INIT_EN
      INIT:
        if (sweep == ADDR_W'(SRAM_DEPTH - 1))
          state_nx = IDLE;
`endif
      IDLE:
        if (req0 && (!req1 || last)) state_nx = SERVE0;
        else if (req1)               state_nx = SERVE1;
      SERVE0:
        if (!req0) begin
          state_nx = req1 ? SERVE1 : IDLE;
        end else begin
          last_nx = 1'b0;
          if (cnt == CNT_TOP) begin
            cnt_nx = '0;
            if (req1) state_nx = SERVE1;
          end else begin
            cnt_nx = cnt + 3'd1;
          end
        end
      SERVE1:
        if (!req1) begin
          state_nx = req0 ? SERVE0 : IDLE;
        end else begin
          last_nx = 1'b1;
          if (cnt == CNT_TOP) begin
            cnt_nx = '0;
            if (req0) state_nx = SERVE0;
          end else begin
            cnt_nx = cnt + 3'd1;
          end
        end
      default: state_nx = IDLE;
    endcase
    // a fresh state always starts a fresh burst
    if (state_nx != state) cnt_nx = '0;
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state)
      SERVE0:  gnt0 = req0;
      SERVE1:  gnt1 = req1;
      default: ;
    endcase
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = INIT_VAL;
    unique case (1'b1)
      gnt0: begin
        mem_we   = we0;
        mem_addr = addr0;
        mem_din  = wdata0;
      end
      gnt1: begin
        mem_we   = we1;
        mem_addr = addr1;
        mem_din  = wdata1;
      end
`ifdef SRAM_ARB_INIT_EN
      busy: begin
        mem_we   = 1'b1;
        mem_addr = sweep;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
    end
  end

  // raw dout is meaningless outside the valid cycle
  assign rdata = (rvalid0 | rvalid1) ? mem_dout : '0;

  sram_1k8 u_sram (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .din  (mem_din),
    .dout (mem_dout)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a read-data scoreboard.
// Honours SRAM_ARB_INIT_EN for the init sweep checks.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

`ifdef SRAM_ARB_INIT_EN
  localparam int   BUSY_CYC = 1024;
  localparam logic RST_BUSY = 1'b1;
`else
  localparam int   BUSY_CYC = 0;
  localparam logic RST_BUSY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       we0 = 1'b0, we1 = 1'b0;
  logic [9:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [7:0] rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] model [int];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic       pend0 = 1'b0, pend1 = 1'b0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .we0     (we0),
    .we1     (we1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1),
    .rdata   (rdata),
    .busy    (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: reads are queued at grant, popped at rvalid
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_outs", {gnt0, gnt1, rvalid0, rvalid1, rdata}, '0);
      q0.delete();
      q1.delete();
      pend0 = 1'b0;
      pend1 = 1'b0;
    end else begin
      chk("one_gnt", {31'd0, gnt0 & gnt1}, 0);
      chk("rvalid0", {31'd0, rvalid0}, {31'd0, pend0});
      chk("rvalid1", {31'd0, rvalid1}, {31'd0, pend1});
      if (pend0 && q0.size() > 0) chk("rdata0", rdata, q0.pop_front());
      if (pend1 && q1.size() > 0) chk("rdata1", rdata, q1.pop_front());
      pend0 = gnt0 && !we0;
      pend1 = gnt1 && !we1;
      if (pend0) q0.push_back(model.exists(addr0) ? model[addr0] : 8'h00);
      if (pend1) q1.push_back(model.exists(addr1) ? model[addr1] : 8'h00);
      if (gnt0 && we0) model[addr0] = wdata0;
      if (gnt1 && we1) model[addr1] = wdata1;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      chk("init_nognt", {gnt1, gnt0}, 0);
      @(negedge clk);
      n++;
    end
    chk("busy_cycles", n, BUSY_CYC);
    if (BUSY_CYC > 0)
      for (int i = 0; i < SRAM_DEPTH; i++) model[i] = 8'h01;
    tick();
  endtask

  task automatic access(input int k, input logic w,
                        input logic [9:0] a, input logic [7:0] d,
                        output int waits);
    if (k == 0) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end
    waits = 0;
    @(negedge clk);
    while (!(k == 0 ? gnt0 : gnt1) && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    chk("grant_seen", {31'd0, waits < 8}, 1);
    tick();
  endtask

  task automatic read_chk(input int k, input logic [9:0] a,
                          input logic [7:0] exp);
    int w;
    access(k, 1'b0, a, 8'h00, w);
    if (k == 0) req0 = 1'b0;
    else        req1 = 1'b0;
    @(negedge clk);
    chk("rd_valid", {31'd0, k == 0 ? rvalid0 : rvalid1}, 1);
    chk("rd_data", rdata, exp);
    tick();
  endtask

  initial begin
    int w;
    logic [1:0] exp_g;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, {31'd0, RST_BUSY});
    tick();
    rst = 1'b1;
    wait_ready();

    // both requesters writing from IDLE: 4/4 alternation starting with 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd20; wdata0 = 8'hA5;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'd21; wdata1 = 8'h5A;
    for (int i = 0; i < 17; i++) begin
      if (i == 0)                exp_g = 2'b00;
      else if (((i - 1) / 4) % 2) exp_g = 2'b10;
      else                       exp_g = 2'b01;
      @(negedge clk);
      chk("contend", {gnt1, gnt0}, exp_g);
    end
    tick();
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) tick();

    if (BUSY_CYC > 0) begin
      read_chk(0, 10'd0, 8'h01);
      read_chk(0, 10'd511, 8'h01);
      read_chk(0, 10'd1023, 8'h01);
    end
    read_chk(1, 10'd20, 8'hA5);
    read_chk(0, 10'd21, 8'h5A);

    // single requester: writes then 10 back-to-back reads
    for (int i = 0; i < 10; i++)
      access(0, 1'b1, 10'(100 + i), 8'(8'h30 + i), w);
    req0 = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 10; i++) begin
      access(0, 1'b0, 10'(100 + i), 8'h00, w);
      chk("stream_wait", w, i == 0 ? 1 : 0);
    end
    req0 = 1'b0;
    repeat (3) tick();

    // write by 1 then read by 0, no idle gap between them
    access(1, 1'b1, 10'd12, 8'h00, w);
    req1 = 1'b0;
    access(0, 1'b0, 10'd12, 8'h00, w);
    chk("coh_wait", w, 1);
    req0 = 1'b0;
    @(negedge clk);
    chk("coh_rvalid0", {31'd0, rvalid0}, 1);
    chk("coh_rdata", rdata, 8'h00);
    tick();
    repeat (2) tick();

    // reset during SERVE1 with a read in flight
    access(1, 1'b0, 10'd101, 8'h00, w);
    @(negedge clk);
    chk("pre_rst_gnt1", {31'd0, gnt1}, 1);
    chk("pre_rst_rv1", {31'd0, rvalid1}, 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_gnt1", {31'd0, gnt1}, 0);
    chk("rst_rvalid1", {31'd0, rvalid1}, 0);
    chk("rst_rdata", rdata, 0);
    req1 = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    wait_ready();
    access(0, 1'b0, 10'd101, 8'h00, w);
    chk("post_rst_wait", w, 1);
    req0 = 1'b0;
    @(negedge clk);
    chk("post_rst_rdata", rdata, BUSY_CYC > 0 ? 8'h01 : 8'h31);
    tick();
    repeat (2) tick();

    chk("sb_empty", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
